// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: channel constants and the
// controller state encoding.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam logic [SEL_W-1:0] LAST_CH = 2'd3;

    // Controller states, kept as plain constants so the encoding stays fixed
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SETTLE = 2'd1;
    localparam state_t SAMPLE = 2'd2;
    localparam state_t HOLD   = 2'd3;

endpackage

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// Settle-time counter for the mux scan sequencer. Counts while enabled and
// flags the terminal count DWELL-1 so the controller knows the mux output
// has had DWELL full cycles to settle.
module dwell_counter
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    // Reject illegal settle times at elaboration rather than misbehave silently
    if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
        $error("dwell_counter: DWELL must lie in 1..15");
    end
    if ((2 ** CNT_W) <= DWELL) begin : g_bad_cnt_w
        $error("dwell_counter: CNT_W too narrow to hold DWELL");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority so the terminal cycle restarts the count at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, zeroed by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan controller for the 4:1 gate-level mux. Steps the select through
// channels 0..3, lets each settle for DWELL cycles, captures y into the
// matching word bit and offers the finished word on a valid/ready handshake.
// Optional build macro: SCAN_PARITY_EN adds a registered parity output.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    output logic [SEL_W-1:0] s,
    input  logic             y,
    output logic [NUM_CH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy
`ifdef SCAN_PARITY_EN
    ,
    output logic             parity
`endif
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [NUM_CH-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              cntEn;
    logic              cntClear;
    logic              dwellDone;

    assign cntEn    = (state_q == SETTLE);
    assign cntClear = !cntEn || dwellDone;

    dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cntClear),
        .en_i    (cntEn),
        .tc_o    (dwellDone)
    );

    // Next-state logic: select only moves on capture or scan-start edges
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        word_d  = word_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    s_d     = '0;
                end
            end
            SETTLE: begin
                if (dwellDone) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                word_d[s_q] = y;
                if (s_q != LAST_CH) begin
                    s_d     = s_q + 1'b1;
                    state_d = SETTLE;
                end else begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (valid_q && word_ready) begin
                    valid_d = 1'b0;
                    if (cont) begin
                        state_d = SETTLE;
                        s_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any scan in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SCAN_PARITY_EN
    logic parity_q;

    // Parity tracks the word register so it is correct whenever valid is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^word_d;
        end
    end

    assign parity = parity_q;
`endif

    assign s          = s_q;
    assign word       = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer. Two instances run against a
// behavioural 4:1 mux in loopback: one with DWELL=2, one with DWELL=1.
// Honours SCAN_PARITY_EN when the design is built with it.
module tb_mux_scan_sequencer;

    localparam int D1 = 2;
    localparam int D2 = 1;
    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst;

    logic       start1, cont1, ready1, y1, valid1, busy1;
    logic [1:0] s1;
    logic [3:0] word1, i1;

    logic       start2, cont2, ready2, y2, valid2, busy2;
    logic [1:0] s2;
    logic [3:0] word2, i2;

`ifdef SCAN_PARITY_EN
    logic       parity1, parity2;
`endif

    int checks = 0;
    int errors = 0;

    assign y1 = i1[s1];
    assign y2 = i2[s2];

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    mux_scan_sequencer #(.DWELL(D1), .CNT_W(4)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .cont       (cont1),
        .s          (s1),
        .y          (y1),
        .word       (word1),
        .word_valid (valid1),
        .word_ready (ready1),
        .busy       (busy1)
`ifdef SCAN_PARITY_EN
        ,
        .parity     (parity1)
`endif
    );

    mux_scan_sequencer #(.DWELL(D2), .CNT_W(4)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .cont       (cont2),
        .s          (s2),
        .y          (y2),
        .word       (word2),
        .word_valid (valid2),
        .word_ready (ready2),
        .busy       (busy2)
`ifdef SCAN_PARITY_EN
        ,
        .parity     (parity2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0; i1 = 4'b0000;
        start2 = 1'b0; cont2 = 1'b0; ready2 = 1'b0; i2 = 4'b0000;
        tick();
        tick();
        checks++;
        if (s1 !== 2'd0 || word1 !== 4'd0 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dut1: s=%0d word=%b valid=%b busy=%b, want 0/0000/0/0",
                     s1, word1, valid1, busy1);
        end
        checks++;
        if (s2 !== 2'd0 || word2 !== 4'd0 || valid2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dut2: s=%0d word=%b valid=%b busy=%b, want 0/0000/0/0",
                     s2, word2, valid2, busy2);
        end
        rst = 1'b0;
        tick();
    endtask

    // One full scan on dut1: select sweep, latency, hold behaviour, handshake.
    // Entered in IDLE when needStart is set, otherwise just after the
    // handshake edge that began this scan in continuous mode.
    task automatic do_scan(input logic [3:0] data, input logic [3:0] nextData,
                           input int rdyDelay, input logic contNext,
                           input bit needStart, input string tag);
        int lat = NCH * (D1 + 1);
        logic [1:0] expS;
        if (needStart) begin
            i1 = data;
            start1 = 1'b1;
            tick();
        end
        for (int k = 0; k < lat; k++) begin
            expS = 2'(k / (D1 + 1));
            checks++;
            if (s1 !== expS || valid1 !== 1'b0 || busy1 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_sweep k=%0d: s=%0d valid=%b busy=%b, want s=%0d valid=0 busy=1",
                         tag, k, s1, valid1, busy1, expS);
            end
            start1 = 1'($urandom_range(0, 1));
            cont1  = 1'($urandom_range(0, 1));
            ready1 = 1'($urandom_range(0, 1));
            tick();
        end
        checks++;
        if (valid1 !== 1'b1 || word1 !== data || s1 !== 2'd3 || busy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_result: valid=%b word=%b s=%0d busy=%b, want 1/%b/3/1",
                     tag, valid1, word1, s1, busy1, data);
        end
`ifdef SCAN_PARITY_EN
        checks++;
        if (parity1 !== ^data) begin
            errors++;
            $display("[TB] FAIL %s_parity: got %b want %b", tag, parity1, ^data);
        end
`endif
        i1 = nextData;
        cont1 = contNext;
        ready1 = 1'b0;
        for (int r = 0; r < rdyDelay; r++) begin
            start1 = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (valid1 !== 1'b1 || word1 !== data || s1 !== 2'd3) begin
                errors++;
                $display("[TB] FAIL %s_hold r=%0d: valid=%b word=%b s=%0d, want 1/%b/3",
                         tag, r, valid1, word1, s1, data);
            end
        end
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        start1 = 1'b0;
        checks++;
        if (valid1 !== 1'b0 || busy1 !== contNext || s1 !== (contNext ? 2'd0 : 2'd3)) begin
            errors++;
            $display("[TB] FAIL %s_handshake: valid=%b busy=%b s=%0d, want 0/%b/%0d",
                     tag, valid1, busy1, s1, contNext, contNext ? 0 : 3);
        end
    endtask

    task automatic test_loopback_basic();
        do_scan(4'b1010, 4'b1010, 0, 1'b0, 1'b1, "basic");
    endtask

    task automatic test_hold_stall();
        do_scan(4'b0110, 4'b0110, 5, 1'b0, 1'b1, "stall");
    endtask

    task automatic test_back_to_back();
        do_scan(4'b1111, 4'b0001, 2, 1'b1, 1'b1, "b2b_first");
        do_scan(4'b0001, 4'b0001, 0, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_midscan();
        i1 = 4'b1111;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 2 * (D1 + 1) + 1; k++) begin
            tick();
        end
        checks++;
        if (s1 !== 2'd2 || busy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midscan_position: s=%0d busy=%b, want 2/1", s1, busy1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s1 !== 2'd0 || word1 !== 4'd0 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midscan_async_reset: s=%0d word=%b valid=%b busy=%b, want 0/0000/0/0",
                     s1, word1, valid1, busy1);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_scan(4'b0101, 4'b0101, 1, 1'b0, 1'b1, "after_reset");
    endtask

    // Free-running start on the DWELL=1 instance. Each repetition is the
    // 4*(DWELL+1) scan edges, one HOLD edge for the handshake and one IDLE
    // edge where start is seen again.
    task automatic test_dwell1();
        int period = NCH * (D2 + 1) + 2;
        int firstRise = NCH * (D2 + 1);
        int rises = 0;
        logic prevValid = 1'b0;
        i2 = 4'($urandom_range(0, 15));
        ready2 = 1'b1;
        cont2 = 1'b0;
        start2 = 1'b1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (valid2 && !prevValid) begin
                checks++;
                if (e !== firstRise + rises * period || word2 !== i2) begin
                    errors++;
                    $display("[TB] FAIL dwell1_rise%0d: edge=%0d word=%b, want edge=%0d word=%b",
                             rises, e, word2, firstRise + rises * period, i2);
                end
                rises++;
            end
            prevValid = valid2;
        end
        start2 = 1'b0;
        checks++;
        if (rises !== 4) begin
            errors++;
            $display("[TB] FAIL dwell1_count: rises=%0d want 4", rises);
        end
        tick();
        tick();
        checks++;
        if (busy2 !== 1'b0 || valid2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dwell1_idle: busy=%b valid=%b, want 0/0", busy2, valid2);
        end
    endtask

    task automatic test_parity_patterns();
        do_scan(4'b1011, 4'b1011, 0, 1'b0, 1'b1, "pattern_1011");
        do_scan(4'b1001, 4'b1001, 1, 1'b0, 1'b1, "pattern_1001");
    endtask

    task automatic test_random();
        logic [3:0] cur = 4'($urandom_range(0, 15));
        logic [3:0] nxt;
        logic       c;
        bit         need = 1'b1;
        for (int n = 0; n < 8; n++) begin
            nxt = 4'($urandom_range(0, 15));
            c = (n < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_scan(cur, nxt, int'($urandom_range(0, 3)), c, need, "random");
            need = !c;
            cur = nxt;
        end
    endtask

    // Runaway guard in case the design wedges the simulation
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        test_reset();
        test_loopback_basic();
        test_hold_stall();
        test_back_to_back();
        test_reset_midscan();
        test_dwell1();
        test_parity_patterns();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
